// File: rtl/blocking_port_arbiter_pkg.sv
// Shared types and helpers for the blocking port arbiter.
// Optional feature macro: ARB_STATS_EN enables per-producer transfer counters.
package blocking_port_arbiter_types;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    localparam int STATS_W = 16;

    // Increment modulo n; works for any n, not only powers of two.
    function automatic int next_ptr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/blocking_port_arbiter_if.sv
// Producer-side and consumer-side blocking handshake bundle for the arbiter.
interface blocking_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_notify;
    logic [N_REQ-1:0]        req_sync;
    logic [DATA_W-1:0]       out_data;
    logic                    out_notify;
    logic                    out_sync;
    logic [PTR_W-1:0]        grant_id;
    logic                    busy;

    // The arbiter sits on the slave side; producers and the consumer drive the master side.
    modport slave (
        input  req_data, req_notify, out_sync,
        output req_sync, out_data, out_notify, grant_id, busy
    );

    modport master (
        output req_data, req_notify, out_sync,
        input  req_sync, out_data, out_notify, grant_id, busy
    );

endinterface

// File: rtl/blocking_port_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Walk from the farthest candidate back to rr_ptr so the closest one is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = PTR_W'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blocking_port_arbiter.sv
// Round-robin arbiter sharing one blocking output port among N_REQ producers.
// Optional feature macro: ARB_STATS_EN adds xfer_count, saturating per-producer transfer counters.
module blocking_port_arbiter
    import blocking_port_arbiter_types::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ARB_STATS_EN
    output logic [N_REQ*STATS_W-1:0] xfer_count,
`endif
    blocking_port_arbiter_if.slave   bus
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [PTR_W-1:0]  grant_id_q, grant_id_d;
    logic [N_REQ-1:0]  req_sync;

    logic [N_REQ-1:0]  sel_grant;
    logic [PTR_W-1:0]  sel_idx;
    logic              sel_any;

    rr_select #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_select (
        .req    (bus.req_notify),
        .rr_ptr (rr_ptr_q),
        .grant  (sel_grant),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        grant_id_d = grant_id_q;
        req_sync   = '0;
        case (state_q)
            IDLE: begin
                req_sync = sel_grant;
                if (sel_any) begin
                    out_data_d = bus.req_data[sel_idx*DATA_W +: DATA_W];
                    grant_id_d = sel_idx;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.out_sync) begin
                    rr_ptr_d = PTR_W'(next_ptr(int'(grant_id_q), N_REQ));
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.req_sync   = req_sync;
    assign bus.out_data   = out_data_q;
    assign bus.out_notify = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.grant_id   = grant_id_q;

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] cnt_q [N_REQ];
    logic [STATS_W-1:0] cnt_d [N_REQ];

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SEND && bus.out_sync && cnt_q[grant_id_q] != '1)
            cnt_d[grant_id_q] = cnt_q[grant_id_q] + 1'b1;
    end

    // NOTE: this small array is architectural state visible on a port, so it is reset like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        assign xfer_count[g*STATS_W +: STATS_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_blocking_port_arbiter.sv
// Randomized self-checking bench for blocking_port_arbiter against a transaction-level model.
module tb_blocking_port_arbiter;
    import blocking_port_arbiter_types::*;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(N_REQ);

    logic clk;
    logic rst;

    blocking_port_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
    logic [N_REQ*STATS_W-1:0] xfer_count;
`endif

    blocking_port_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ARB_STATS_EN
        .xfer_count (xfer_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one pending word, a rotating start index, per-producer counts.
    bit                m_sending;
    int                m_ptr;
    int                m_grant;
    logic [DATA_W-1:0] m_word;
    int                m_count [N_REQ];
    int                last_win;
    int                win_q [$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_sending = 1'b0;
        m_ptr     = 0;
        m_grant   = 0;
        m_word    = '0;
        for (int i = 0; i < N_REQ; i++) m_count[i] = 0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model
    // to what the next rising edge should produce.
    task automatic step(input logic [N_REQ-1:0] notify,
                        input logic [N_REQ*DATA_W-1:0] data,
                        input logic osync);
        logic [N_REQ-1:0] exp_sync;
        int win;
        @(negedge clk);
        bus.req_notify = notify;
        bus.req_data   = data;
        bus.out_sync   = osync;
        #1;
        win      = -1;
        exp_sync = '0;
        if (!m_sending)
            for (int k = 0; k < N_REQ; k++)
                if (win < 0 && notify[(m_ptr + k) % N_REQ]) win = (m_ptr + k) % N_REQ;
        if (win >= 0) exp_sync[win] = 1'b1;
        check("req_sync",   64'(bus.req_sync),   64'(exp_sync));
        check("out_notify", 64'(bus.out_notify), 64'(m_sending));
        check("busy",       64'(bus.busy),       64'(m_sending));
        check("out_data",   64'(bus.out_data),   64'(m_word));
        check("grant_id",   64'(bus.grant_id),   64'(m_grant));
        last_win = win;
        if (m_sending) begin
            if (osync) begin
                m_sending = 1'b0;
                m_ptr     = (m_grant + 1) % N_REQ;
                if (m_count[m_grant] < 65535) m_count[m_grant]++;
            end
        end else if (win >= 0) begin
            m_sending = 1'b1;
            m_word    = data[win*DATA_W +: DATA_W];
            m_grant   = win;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_notify = '0;
        bus.req_data   = '0;
        bus.out_sync   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [N_REQ*DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [N_REQ*DATA_W-1:0] d;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        rst            = 1'b1;
        bus.req_notify = '0;
        bus.req_data   = '0;
        bus.out_sync   = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_out_notify", 64'(bus.out_notify), 64'd0);
        check("rst_busy",       64'(bus.busy),       64'd0);
        check("rst_out_data",   64'(bus.out_data),   64'd0);
        check("rst_grant_id",   64'(bus.grant_id),   64'd0);
        do_reset();

        // Idle with no requests, out_sync toggling is ignored.
        for (int i = 0; i < 10; i++) step('0, rand_data(), 1'(i % 2));

        // Single word from producer 2.
        d = rand_data();
        d[2*DATA_W +: DATA_W] = 32'd42;
        step(4'b0100, d, 1'b0);
        check("single_req_sync", 64'(bus.req_sync), 64'b0100);
        step('0, rand_data(), 1'b0);
        check("single_out_data",   64'(bus.out_data),   64'd42);
        check("single_out_notify", 64'(bus.out_notify), 64'd1);
        check("single_grant_id",   64'(bus.grant_id),   64'd2);
        step('0, rand_data(), 1'b1);

        // All four requesting with out_sync held: 0,1,2,3,0 at one word per two cycles.
        do_reset();
        win_q.delete();
        for (int i = 0; i < 10; i++) begin
            step(4'hF, rand_data(), 1'b1);
            if (last_win >= 0) win_q.push_back(last_win);
        end
        check("rr_words_in_10", 64'(win_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < win_q.size(); i++)
            check("rr_order", 64'(win_q[i]), 64'(exp_order[i]));

        // Backpressure: word held, no new captures, release returns to IDLE next cycle.
        d = rand_data();
        d[1*DATA_W +: DATA_W] = 32'h0000_00AB;
        step(4'b0010, d, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, rand_data(), 1'b0);
            check("bp_out_data", 64'(bus.out_data), 64'hAB);
            check("bp_req_sync", 64'(bus.req_sync), 64'd0);
        end
        step(4'hF, rand_data(), 1'b1);
        step('0, rand_data(), 1'b0);
        check("bp_released_busy", 64'(bus.busy), 64'd0);

        // Reset in SEND: make the pointer nonzero first, then hold word 7 and reset.
        d = rand_data();
        d[2*DATA_W +: DATA_W] = 32'd5;
        step(4'b0100, d, 1'b0);
        step('0, rand_data(), 1'b1);
        d[2*DATA_W +: DATA_W] = 32'd7;
        step(4'b0100, d, 1'b0);
        step('0, rand_data(), 1'b0);
        check("pre_rst_out_data", 64'(bus.out_data), 64'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_out_notify", 64'(bus.out_notify), 64'd0);
        check("mid_rst_busy",       64'(bus.busy),       64'd0);
        check("mid_rst_out_data",   64'(bus.out_data),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b1001, rand_data(), 1'b0);
        check("post_rst_search_from_0", 64'(bus.req_sync), 64'b0001);
        step('0, rand_data(), 1'b1);

`ifdef ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, rand_data(), 1'b0);
            step('0, rand_data(), 1'b1);
        end
        step('0, rand_data(), 1'b0);
        check("stats_slot1", 64'(xfer_count[1*STATS_W +: STATS_W]), 64'd3);
`endif

        // Randomized traffic including a lone requester and dropping requests.
        for (int i = 0; i < 400; i++) begin
            logic [N_REQ-1:0] n;
            n = (i < 40) ? 4'b1000 : N_REQ'($urandom);
            step(n, rand_data(), 1'($urandom_range(0, 2) != 0));
        end
        step('0, rand_data(), 1'b0);

`ifdef ARB_STATS_EN
        for (int i = 0; i < N_REQ; i++)
            check("stats_random", 64'(xfer_count[i*STATS_W +: STATS_W]), 64'(m_count[i]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
